// File: rtl/rtc_bus_interface_pkg.sv
// Shared definitions for the RTC bus interface.
// Contents:
//   state_t        - bus sequencer states (4-bit encoding)
//   DEF_T_*        - default phase timings in clock cycles
//   RD_WR_READ     - rd_wr polarity meaning "read", shared with the control top
//   bus_drive_t    - bundle of registered pad-side outputs
//   bus_drive()    - pad output values for a given state and latched access
package rtc_bus_interface_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_A_SETUP  = 4'd1,
        ST_A_STROBE = 4'd2,
        ST_A_HOLD   = 4'd3,
        ST_GAP      = 4'd4,
        ST_D_SETUP  = 4'd5,
        ST_D_STROBE = 4'd6,
        ST_D_HOLD   = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    localparam int DEF_T_SU  = 4;
    localparam int DEF_T_PW  = 10;
    localparam int DEF_T_HD  = 4;
    localparam int DEF_T_GAP = 6;

    localparam logic RD_WR_READ = 1'b1;

    typedef struct packed {
        logic       ad_sel;
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       ad_oe;
        logic [7:0] ad_out;
    } bus_drive_t;

    localparam bus_drive_t BUS_IDLE = '{ad_sel: 1'b1, cs_n: 1'b1, rd_n: 1'b1,
                                        wr_n: 1'b1, ad_oe: 1'b0, ad_out: 8'h00};

    function automatic bus_drive_t bus_drive(input state_t st, input logic is_read,
                                             input logic [7:0] addr, input logic [7:0] wdata);
        bus_drive_t b;
        b = BUS_IDLE;
        case (st)
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                // Address is always written to the RTC, even for register reads.
                b.ad_sel = 1'b0;
                b.cs_n   = 1'b0;
                b.ad_oe  = 1'b1;
                b.ad_out = addr;
                b.wr_n   = (st != ST_A_STROBE);
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                b.cs_n = 1'b0;
                if (is_read) begin
                    // Pad released so the RTC can drive AD.
                    b.rd_n = (st != ST_D_STROBE);
                end else begin
                    b.ad_oe  = 1'b1;
                    b.ad_out = wdata;
                    b.wr_n   = (st != ST_D_STROBE);
                end
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rtc_bus_interface_if.sv
// Pad-side multiplexed RTC bus.
//   ad_in  - AD value seen at the pad
//   ad_out - AD value to drive, ad_oe - 1 = FPGA drives AD
//   ad_sel - A/D pin (0 = address, 1 = data)
//   cs_n, rd_n, wr_n - active-low chip select and strobes
// master: the bus sequencer; slave: the RTC side (or a model of it).
interface rtc_bus_interface_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       ad_sel;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n
    );
endinterface

// File: rtl/rtc_bus_interface_phase_timer.sv
// phase_timer: 8-bit loadable down-counter timing each bus phase.
//   clk, reset      - clock and synchronous active-high reset
//   load/load_value - reload the counter (takes priority over counting)
//   value           - current count
//   zero            - count has reached 0 (counter then holds at 0)
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] value,
    output logic       zero
);
    logic [7:0] value_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg <= 8'd0;
        end else if (load) begin
            value_reg <= load_value;
        end else if (value_reg != 8'd0) begin
            value_reg <= value_reg - 8'd1;
        end
    end

    assign value = value_reg;
    assign zero  = (value_reg == 8'd0);
endmodule

// File: rtl/rtc_bus_interface.sv
// rtc_bus_interface: runs one RTC register access (address phase, CS-high
// gap, data phase) on the multiplexed AD bus with programmable timing.
//   T_SU/T_PW/T_HD/T_GAP - setup, strobe, hold and gap lengths in cycles (1..255)
//   clk, reset           - clock and synchronous active-high reset
//   req, rd_wr, dir, dato_wr - access request from the control top
//   bus                  - pad-side AD bus (master modport)
//   dato_rtc             - last read data, held until the next read completes
//   busy, done           - access in progress / one-cycle completion pulse
module rtc_bus_interface
    import rtc_bus_interface_pkg::*;
#(
    parameter int T_SU  = DEF_T_SU,
    parameter int T_PW  = DEF_T_PW,
    parameter int T_HD  = DEF_T_HD,
    parameter int T_GAP = DEF_T_GAP
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic                       rd_wr,
    input  logic [7:0]                 dir,
    input  logic [7:0]                 dato_wr,
    rtc_bus_interface_if.master        bus,
    output logic [7:0]                 dato_rtc,
    output logic                       busy,
    output logic                       done
);
    // Request inputs pass through one capture register; this puts the first
    // bus cycle one edge after req is sampled and makes a req seen during
    // the DONE cycle land while the sequencer is still busy.
    logic       req_in_reg;
    logic       rd_wr_in_reg;
    logic [7:0] dir_in_reg;
    logic [7:0] dato_in_reg;

    state_t     state_reg, state_next;
    logic       is_read_reg;
    logic [7:0] addr_reg;
    logic [7:0] wdata_reg;
    bus_drive_t bus_reg;

    logic       timer_load;
    logic [7:0] timer_load_value;
    logic [7:0] timer_value;
    logic       timer_zero;

    logic       is_read_next;
    logic [7:0] addr_next;
    logic [7:0] wdata_next;

    phase_timer u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_load_value),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (req_in_reg) state_next = ST_A_SETUP;
            ST_A_SETUP:  if (timer_zero) state_next = ST_A_STROBE;
            ST_A_STROBE: if (timer_zero) state_next = ST_A_HOLD;
            ST_A_HOLD:   if (timer_zero) state_next = ST_GAP;
            ST_GAP:      if (timer_zero) state_next = ST_D_SETUP;
            ST_D_SETUP:  if (timer_zero) state_next = ST_D_STROBE;
            ST_D_STROBE: if (timer_zero) state_next = ST_D_HOLD;
            ST_D_HOLD:   if (timer_zero) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase

        // Every state differs from its successor, so a state change is
        // exactly a state entry and reloads the timer.
        timer_load = (state_next != state_reg);
        case (state_next)
            ST_A_SETUP, ST_D_SETUP:   timer_load_value = 8'(T_SU - 1);
            ST_A_STROBE, ST_D_STROBE: timer_load_value = 8'(T_PW - 1);
            ST_A_HOLD, ST_D_HOLD:     timer_load_value = 8'(T_HD - 1);
            ST_GAP:                   timer_load_value = 8'(T_GAP - 1);
            default:                  timer_load_value = 8'd0;
        endcase

        // On acceptance the outputs for A_SETUP are computed from the
        // captured request, not from the latches that load on the same edge.
        if (state_reg == ST_IDLE) begin
            is_read_next = (rd_wr_in_reg == RD_WR_READ);
            addr_next    = dir_in_reg;
            wdata_next   = dato_in_reg;
        end else begin
            is_read_next = is_read_reg;
            addr_next    = addr_reg;
            wdata_next   = wdata_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_in_reg   <= 1'b0;
            rd_wr_in_reg <= 1'b0;
            dir_in_reg   <= 8'h00;
            dato_in_reg  <= 8'h00;
            state_reg    <= ST_IDLE;
            is_read_reg  <= 1'b0;
            addr_reg     <= 8'h00;
            wdata_reg    <= 8'h00;
            bus_reg      <= BUS_IDLE;
            dato_rtc     <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            req_in_reg   <= req;
            rd_wr_in_reg <= rd_wr;
            dir_in_reg   <= dir;
            dato_in_reg  <= dato_wr;
            state_reg    <= state_next;
            is_read_reg  <= is_read_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            bus_reg      <= bus_drive(state_next, is_read_next, addr_next, wdata_next);
            busy         <= (state_next != ST_IDLE);
            done         <= (state_next == ST_DONE);
            // Sample AD at the end of the last read-strobe cycle.
            if (state_reg == ST_D_STROBE && is_read_reg && timer_value == 8'd0) begin
                dato_rtc <= bus.ad_in;
            end
        end
    end

    assign bus.ad_sel = bus_reg.ad_sel;
    assign bus.cs_n   = bus_reg.cs_n;
    assign bus.rd_n   = bus_reg.rd_n;
    assign bus.wr_n   = bus_reg.wr_n;
    assign bus.ad_oe  = bus_reg.ad_oe;
    assign bus.ad_out = bus_reg.ad_out;
endmodule

// File: tb/tb_rtc_bus_interface.sv
// Directed bench for rtc_bus_interface: a default-timing instance (dut0) and
// a minimum-timing instance (dut1), each with a simple RTC read model.
module tb_rtc_bus_interface;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       rd_wr = 1'b0;
    logic [7:0] dir = 8'h00;
    logic [7:0] dato_wr = 8'h00;
    logic [7:0] rtc_data = 8'h59;
    logic [7:0] dato_rtc0, dato_rtc1;
    logic       busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] IDLE_VEC = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    localparam logic [14:0] OUT_MASK = 15'h03FC;

    always #5 clk = ~clk;

    rtc_bus_interface_if bus0 ();
    rtc_bus_interface_if bus1 ();

    // RTC model: drives its register value onto AD while RD is low.
    assign bus0.ad_in = (bus0.rd_n == 1'b0) ? rtc_data : 8'h00;
    assign bus1.ad_in = (bus1.rd_n == 1'b0) ? rtc_data : 8'h00;

    rtc_bus_interface dut0 (
        .clk(clk), .reset(reset), .req(req0), .rd_wr(rd_wr), .dir(dir),
        .dato_wr(dato_wr), .bus(bus0), .dato_rtc(dato_rtc0), .busy(busy0), .done(done0)
    );

    rtc_bus_interface #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .rd_wr(rd_wr), .dir(dir),
        .dato_wr(dato_wr), .bus(bus1), .dato_rtc(dato_rtc1), .busy(busy1), .done(done1)
    );

    // Address/data must not move while a strobe stays low.
    logic       prev_low0 = 1'b0, prev_low1 = 1'b0;
    logic [8:0] prev_ad0 = 9'h0, prev_ad1 = 9'h0;
    always @(negedge clk) begin
        if (!reset && prev_low0 && (bus0.rd_n === 1'b0 || bus0.wr_n === 1'b0)) begin
            checks++;
            if ({bus0.ad_sel, bus0.ad_out} !== prev_ad0) begin
                errors++;
                $display("FAIL strobe_stable dut0: ad_sel/ad_out=%h was %h", {bus0.ad_sel, bus0.ad_out}, prev_ad0);
            end
        end
        if (!reset && prev_low1 && (bus1.rd_n === 1'b0 || bus1.wr_n === 1'b0)) begin
            checks++;
            if ({bus1.ad_sel, bus1.ad_out} !== prev_ad1) begin
                errors++;
                $display("FAIL strobe_stable dut1: ad_sel/ad_out=%h was %h", {bus1.ad_sel, bus1.ad_out}, prev_ad1);
            end
        end
        prev_low0 = (bus0.rd_n === 1'b0 || bus0.wr_n === 1'b0);
        prev_low1 = (bus1.rd_n === 1'b0 || bus1.wr_n === 1'b0);
        prev_ad0  = {bus0.ad_sel, bus0.ad_out};
        prev_ad1  = {bus1.ad_sel, bus1.ad_out};
    end

    // Observed vector: {ad_sel, cs_n, rd_n, wr_n, ad_oe, ad_out, busy, done}
    function automatic logic [14:0] observe(input bit which);
        if (which)
            return {bus1.ad_sel, bus1.cs_n, bus1.rd_n, bus1.wr_n, bus1.ad_oe, bus1.ad_out, busy1, done1};
        return {bus0.ad_sel, bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_oe, bus0.ad_out, busy0, done0};
    endfunction

    // Expected vector for the cycle starting at edge k+n (req sampled at edge k).
    // Bit 15 flags ad_out as don't-care (read data phase, pad not driven).
    function automatic logic [15:0] expect_vec(input int n, input int su, input int pw, input int hd,
                                               input int gap, input bit rd,
                                               input logic [7:0] a, input logic [7:0] d);
        int b1 = su;
        int b2 = b1 + pw;
        int b3 = b2 + hd;
        int b4 = b3 + gap;
        int b5 = b4 + su;
        int b6 = b5 + pw;
        int b7 = b6 + hd;
        logic sel = 1'b1, cs = 1'b1, rdn = 1'b1, wrn = 1'b1, oe = 1'b0, bsy = 1'b0, dn = 1'b0, dc = 1'b0;
        logic [7:0] out = 8'h00;
        if (n >= 1 && n <= b7 + 1) bsy = 1'b1;
        if (n == b7 + 1) dn = 1'b1;
        if (n >= 1 && n <= b3) begin
            sel = 1'b0; cs = 1'b0; oe = 1'b1; out = a;
            if (n > b1 && n <= b2) wrn = 1'b0;
        end else if (n > b4 && n <= b7) begin
            cs = 1'b0;
            if (rd) begin
                dc = 1'b1;
                if (n > b5 && n <= b6) rdn = 1'b0;
            end else begin
                oe = 1'b1; out = d;
                if (n > b5 && n <= b6) wrn = 1'b0;
            end
        end
        return {dc, sel, cs, rdn, wrn, oe, out, bsy, dn};
    endfunction

    task automatic set_req(input bit which, input logic v);
        if (which) req1 = v; else req0 = v;
    endtask

    // One access with cycle-by-cycle checks; optional req pulses (sampled at
    // edge k+pulse+1) must be ignored. Inputs are scrambled after acceptance.
    task automatic run_access(input bit which, input bit rd, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] exp_dato, input int pulse_a, input int pulse_b);
        int su  = which ? 1 : 10'd4;
        int pw  = which ? 1 : 10;
        int hd  = which ? 1 : 4;
        int gap = which ? 1 : 6;
        int last = 2 * (su + pw + hd) + gap + 1;
        logic [15:0] e;
        logic [14:0] o;
        logic [7:0] got_dato;
        @(negedge clk);
        rd_wr = rd; dir = a; dato_wr = d;
        set_req(which, 1'b1);
        @(posedge clk);
        for (int n = 0; n <= last + 3; n++) begin
            @(negedge clk);
            e = expect_vec(n, su, pw, hd, gap, rd, a, d);
            o = observe(which);
            if (e[15]) begin
                o = o & ~OUT_MASK;
                e[14:0] = e[14:0] & ~OUT_MASK;
            end
            checks++;
            if (o !== e[14:0]) begin
                errors++;
                $display("FAIL bus_cycle dut%0d n=%0d: got %b required %b", which, n, o, e[14:0]);
            end
            set_req(which, (n == pulse_a || n == pulse_b) ? 1'b1 : 1'b0);
            if (n == 2) begin
                dir = ~a; dato_wr = ~d; rd_wr = ~rd;
            end
        end
        got_dato = which ? dato_rtc1 : dato_rtc0;
        checks++;
        if (got_dato !== exp_dato) begin
            errors++;
            $display("FAIL dato_rtc dut%0d: got %02h required %02h", which, got_dato, exp_dato);
        end
        $display("access dut%0d %s addr=%02h wdata=%02h dato_rtc=%02h", which,
                 rd ? "read " : "write", a, d, got_dato);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (observe(1'b0) !== IDLE_VEC || dato_rtc0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_dut0: got %b/%02h required %b/00", observe(1'b0), dato_rtc0, IDLE_VEC);
        end
        checks++;
        if (observe(1'b1) !== IDLE_VEC || dato_rtc1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_dut1: got %b/%02h required %b/00", observe(1'b1), dato_rtc1, IDLE_VEC);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (observe(1'b0) !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_release: got %b required %b", observe(1'b0), IDLE_VEC);
        end
        $display("reset done");
    endtask

    task automatic test_write;
        run_access(1'b0, 1'b0, 8'h21, 8'h45, 8'h00, -1, -1);
    endtask

    task automatic test_read;
        rtc_data = 8'h59;
        run_access(1'b0, 1'b1, 8'h23, 8'h00, 8'h59, -1, -1);
        // A write afterwards must leave the read data alone.
        run_access(1'b0, 1'b0, 8'h30, 8'hA5, 8'h59, -1, -1);
    endtask

    task automatic test_short_timing;
        run_access(1'b1, 1'b0, 8'h21, 8'h45, 8'h00, -1, -1);
        run_access(1'b1, 1'b1, 8'h23, 8'h00, 8'h59, -1, -1);
    endtask

    task automatic test_ignore_req;
        // Pulses sampled mid-access (edge k+21) and at the edge DONE begins (k+43).
        run_access(1'b0, 1'b0, 8'h0F, 8'hF0, 8'h59, 20, 42);
    endtask

    task automatic test_back_to_back;
        logic [15:0] e;
        logic [14:0] o;
        int m;
        @(negedge clk);
        rd_wr = 1'b0; dir = 8'h21; dato_wr = 8'h45; req0 = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 134; n++) begin
            @(negedge clk);
            m = (n < 132) ? (n % 44) : (n - 88);
            e = expect_vec(m, 4, 10, 4, 6, 1'b0, 8'h21, 8'h45);
            o = observe(1'b0);
            checks++;
            if (o !== e[14:0]) begin
                errors++;
                $display("FAIL back_to_back n=%0d: got %b required %b", n, o, e[14:0]);
            end
            if (n == 0 || n == 44 || n == 88)
                $display("access dut0 write addr=21 wdata=45 accepted at k+%0d", n);
            if (n == 89) req0 = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        bit saw_done = 1'b0;
        @(negedge clk);
        rd_wr = 1'b1; dir = 8'h23; req0 = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 30; n++) begin
            @(negedge clk);
            req0 = 1'b0;
        end
        // Now in D_STROBE of the read with rd_n low.
        checks++;
        if (bus0.rd_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_strobe: rd_n got %b required 0", bus0.rd_n);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (observe(1'b0) !== IDLE_VEC || dato_rtc0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: got %b/%02h required %b/00", observe(1'b0), dato_rtc0, IDLE_VEC);
        end
        reset = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (done0 === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done: done got 1 required 0");
        end
        $display("access dut0 read  addr=23 abandoned by reset");
        rtc_data = 8'h3C;
        run_access(1'b0, 1'b1, 8'h23, 8'h00, 8'h3C, -1, -1);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_short_timing;
        test_ignore_req;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtc_bus_interface.md
# rtc_bus_interface

Physical bus stage for the real-time clock: takes one register access (address, write data, read/write flag) from the control state machine and drives the RTC's multiplexed address/data bus (A/D select, CS, RD, WR, 8-bit AD) with programmable setup/strobe/hold timing. Each access is an address phase followed by a data phase. The block returns read data with a one-cycle `done` pulse. It sits directly downstream of the RTC control top (which produces `dir_out`, `dato`, `RD_WR`) and upstream of the FPGA pad tristate buffer.

## Interface
- `T_SU`, 4: setup cycles, bus driven and CS low before strobe (1..255)
- `T_PW`, 10: RD/WR strobe low width in cycles (1..255)
- `T_HD`, 4: hold cycles after strobe rises, CS still low (1..255)
- `T_GAP`, 6: CS-high cycles between address and data phase (1..255)
- `clk` in 1: system clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `req` in 1: start an access; sampled only in IDLE
- `rd_wr` in 1: 1 = read RTC register, 0 = write
- `dir` in 8: RTC register address
- `dato_wr` in 8: write data (ignored for reads)
- `ad_in` in 8: AD bus value from pad
- `ad_out` out 8: AD bus value to pad
- `ad_oe` out 1: 1 = FPGA drives AD
- `ad_sel` out 1: A/D pin, 0 = address phase, 1 = data
- `cs_n`, `rd_n`, `wr_n` out 1 each: active-low chip select, read, write strobes
- `dato_rtc` out 8: last read data, held until next read completes
- `busy` out 1: high from cycle after accepted `req` through DONE
- `done` out 1: one-cycle pulse at end of access

## Operation
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE.
- IDLE with `req`=1: latch `dir`, `dato_wr`, `rd_wr` → A_SETUP; otherwise stay.
- Each timed state lasts its parameter in cycles (A/D_SETUP=T_SU, A/D_STROBE=T_PW, A/D_HOLD=T_HD, GAP=T_GAP), then advances; DONE lasts 1 cycle → IDLE.
- 8-bit down-counter loaded with (param−1) on state entry; advance when it reads 0.
- Outputs per state (all registered, glitch-free):
  - A_SETUP/A_STROBE/A_HOLD: `ad_sel`=0, `cs_n`=0, `ad_oe`=1, `ad_out`=latched dir; `wr_n`=0 only in A_STROBE; `rd_n`=1.
  - GAP, IDLE, DONE: `cs_n`=`rd_n`=`wr_n`=1, `ad_sel`=1, `ad_oe`=0, `ad_out`=0.
  - D_* write: `ad_sel`=1, `cs_n`=0, `ad_oe`=1, `ad_out`=latched data; `wr_n`=0 only in D_STROBE.
  - D_* read: `ad_sel`=1, `cs_n`=0, `ad_oe`=0; `rd_n`=0 only in D_STROBE; `ad_in` captured into `dato_rtc` on the last D_STROBE cycle.
- `dato_rtc` unchanged by writes.
- `req` while not IDLE (including the DONE cycle) is ignored, not queued.
- Input changes after acceptance have no effect on the access in flight.

## Timing
- Reset values: `cs_n`=`rd_n`=`wr_n`=1, `ad_sel`=1, `ad_oe`=0, `ad_out`=0, `dato_rtc`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- `req` sampled high at edge k → state/outputs of A_SETUP visible from edge k+1.
- `done` high for exactly the cycle starting at edge k+1+2·(T_SU+T_PW+T_HD)+T_GAP. Defaults: k+43. Earliest next accepted `req` is at edge k+44.
- `busy` high from edge k+1 through the DONE cycle inclusive.
- `dato_rtc` valid no later than the `done` cycle.
- Strobe never low while `ad_sel` or `ad_out` changes: address/data are stable T_SU cycles before and T_HD cycles after each strobe.
- `reset` mid-access: at the next edge all outputs take reset values, `dato_rtc` clears, and the access is abandoned with no `done`.

## Structure
- Shared header `rtc_bus_defs.vh`:
  - state encodings (4-bit localparams)
  - default timing constants
  - RD_WR polarity constant (1 = read), shared with the control top
- One sub-module, `phase_timer`: 8-bit loadable down-counter with `load`, `value`, `zero` outputs.
- The pad tristate (`ad_out`/`ad_oe`/`ad_in`) stays at chip top, not in this block.

## Test plan
- Write, defaults: `dir`=0x21, `dato_wr`=0x45, `rd_wr`=0 → `ad_out`=0x21 with `ad_sel`=0 and `wr_n` low 10 cycles, then `ad_out`=0x45 with `ad_sel`=1 and `wr_n` low 10 cycles; `done` at k+43; `rd_n` always 1.
- Read: `dir`=0x23, `rd_wr`=1, model drives `ad_in`=0x59 while `rd_n`=0 → `ad_oe`=0 in data phase, `dato_rtc`=0x59 at `done`; a subsequent write leaves it 0x59.
- Timing check with T_SU=1, T_PW=1, T_HD=1, T_GAP=1 → `done` at k+8; assertion: no `ad_out`/`ad_sel` change while any strobe low.
- `req` held high continuously → accesses accepted at k, k+44, k+88; `req` pulsed during busy and during DONE → ignored, `busy` never drops mid-access.
- `reset` asserted in D_STROBE of a read → next cycle `cs_n`=`rd_n`=1, `ad_oe`=0, `dato_rtc`=0, no `done`; a new `req` after release completes normally.
